// File: rtl/vx_alu_lane_splitter_pkg.sv
// Shared types and width derivations for the ALU lane splitter.
// The packet, pid and tid widths are derived here so that every user computes them the same way.
package vx_alu_lane_splitter_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } split_state_e;

  // Index width that never collapses to zero bits for single-entry ranges.
  function automatic int unsigned up_clog2(input int unsigned n);
    int unsigned w;
    w = (n > 1) ? int'($clog2(n)) : 1;
    return w;
  endfunction

  function automatic int unsigned num_packets(input int unsigned threads,
                                              input int unsigned lanes);
    return threads / lanes;
  endfunction

endpackage

// File: rtl/vx_alu_lane_splitter_prio_enc.sv
// Lowest-index-first priority encoder.
// valid_o is low and index_o is zero when no request bit is set.
module vx_alu_lane_splitter_prio_enc #(
  parameter int unsigned N = 2,
  parameter int unsigned W = 1
) (
  input  logic [N-1:0] data_i,
  output logic [W-1:0] index_o,
  output logic         valid_o
);

  always_comb begin
    logic found;
    found   = 1'b0;
    index_o = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (data_i[i] && !found) begin
        index_o = W'(i);
        found   = 1'b1;
      end
    end
    valid_o = found;
  end

endmodule

// File: rtl/vx_alu_lane_splitter.sv
// Splits a warp ALU instruction into NUM_LANES-wide packets, emitting only packets
// with active threads in ascending pid order (one packet for an all-zero mask).
module vx_alu_lane_splitter
  import vx_alu_lane_splitter_pkg::*;
#(
  parameter int unsigned NUM_THREADS = 4,
  parameter int unsigned NUM_LANES   = 2,
  parameter int unsigned XLEN        = 32,
  parameter int unsigned META_WIDTH  = 64,
  localparam int unsigned NUM_PACKETS = num_packets(NUM_THREADS, NUM_LANES),
  localparam int unsigned PID_WIDTH   = up_clog2(NUM_PACKETS),
  localparam int unsigned TID_WIDTH   = up_clog2(NUM_THREADS)
) (
  input  logic                        clk,
  input  logic                        reset,

  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NUM_THREADS-1:0]      in_tmask,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs1_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs2_data,
  input  logic [NUM_THREADS*XLEN-1:0] in_rs3_data,
  input  logic [TID_WIDTH-1:0]        in_tid,
  input  logic [META_WIDTH-1:0]       in_meta,

  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NUM_LANES-1:0]        out_tmask,
  output logic [NUM_LANES*XLEN-1:0]   out_rs1_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs2_data,
  output logic [NUM_LANES*XLEN-1:0]   out_rs3_data,
  output logic [TID_WIDTH-1:0]        out_tid,
  output logic [META_WIDTH-1:0]       out_meta,
  output logic [PID_WIDTH-1:0]        out_pid,
  output logic                        out_sop,
  output logic                        out_eop
);

  localparam int unsigned LW = NUM_LANES * XLEN;

  split_state_e                state_q, state_d;
  logic [PID_WIDTH-1:0]        pid_q, pid_d;
  logic                        sop_q, sop_d;
  logic [NUM_THREADS-1:0]      tmask_q, tmask_d;
  logic [NUM_THREADS*XLEN-1:0] rs1_q, rs2_q, rs3_q;
  logic [TID_WIDTH-1:0]        tid_q;
  logic [META_WIDTH-1:0]       meta_q;

  logic [NUM_PACKETS-1:0]      slice_nz;
  logic [NUM_PACKETS-1:0]      in_slice_nz;
  logic [NUM_PACKETS-1:0]      higher_nz;
  logic [PID_WIDTH-1:0]        first_pid;
  logic [PID_WIDTH-1:0]        next_pid;
  logic                        next_vld;
  logic                        in_fire;
  logic                        out_fire;

  always_comb begin
    for (int unsigned p = 0; p < NUM_PACKETS; p++) begin
      slice_nz[p]    = |tmask_q[p*NUM_LANES +: NUM_LANES];
      in_slice_nz[p] = |in_tmask[p*NUM_LANES +: NUM_LANES];
    end
  end

  // Keep only non-empty packets strictly above the current pid,
  // i.e. nonzero-slice mask & ~((1 << (pid+1)) - 1).
  always_comb begin
    for (int unsigned p = 0; p < NUM_PACKETS; p++) begin
      higher_nz[p] = slice_nz[p] && (PID_WIDTH'(p) > pid_q);
    end
  end

  vx_alu_lane_splitter_prio_enc #(
    .N (NUM_PACKETS),
    .W (PID_WIDTH)
  ) u_next_pid (
    .data_i  (higher_nz),
    .index_o (next_pid),
    .valid_o (next_vld)
  );

  // Starting packet of a new instruction; an all-zero mask starts (and ends) at pid 0.
  always_comb begin
    logic found;
    found     = 1'b0;
    first_pid = '0;
    for (int unsigned p = 0; p < NUM_PACKETS; p++) begin
      if (in_slice_nz[p] && !found) begin
        first_pid = PID_WIDTH'(p);
        found     = 1'b1;
      end
    end
  end

  assign out_valid = (state_q == ST_BUSY);
  assign out_eop   = ~next_vld;
  assign out_sop   = sop_q;
  assign out_pid   = pid_q;
  assign out_tid   = tid_q;
  assign out_meta  = meta_q;
  assign in_ready  = (state_q == ST_IDLE) || (out_ready && out_eop);
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready;

  always_comb begin
    out_tmask    = '0;
    out_rs1_data = '0;
    out_rs2_data = '0;
    out_rs3_data = '0;
    for (int unsigned p = 0; p < NUM_PACKETS; p++) begin
      if (pid_q == PID_WIDTH'(p)) begin
        out_tmask    = tmask_q[p*NUM_LANES +: NUM_LANES];
        out_rs1_data = rs1_q[p*LW +: LW];
        out_rs2_data = rs2_q[p*LW +: LW];
        out_rs3_data = rs3_q[p*LW +: LW];
      end
    end
  end

  // A new instruction takes priority: it can only fire here alongside the eop packet.
  always_comb begin
    state_d = state_q;
    pid_d   = pid_q;
    sop_d   = sop_q;
    tmask_d = tmask_q;
    if (in_fire) begin
      state_d = ST_BUSY;
      pid_d   = first_pid;
      sop_d   = 1'b1;
      tmask_d = in_tmask;
    end else if (out_fire) begin
      if (out_eop) begin
        state_d = ST_IDLE;
      end else begin
        pid_d = next_pid;
        sop_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pid_q   <= '0;
      sop_q   <= 1'b0;
      tmask_q <= '0;
    end else begin
      state_q <= state_d;
      pid_q   <= pid_d;
      sop_q   <= sop_d;
      tmask_q <= tmask_d;
    end
  end

  always_ff @(posedge clk) begin
    if (in_fire) begin
      rs1_q  <= in_rs1_data;
      rs2_q  <= in_rs2_data;
      rs3_q  <= in_rs3_data;
      tid_q  <= in_tid;
      meta_q <= in_meta;
    end
  end

endmodule

// File: tb/tb_vx_alu_lane_splitter.sv
// Scoreboard bench for vx_alu_lane_splitter (4 threads, 2 lanes): each accepted
// instruction is expanded into its expected packet list, a forked monitor checks every packet.
module tb_vx_alu_lane_splitter;

  localparam int NT = 4;
  localparam int NL = 2;
  localparam int XL = 32;
  localparam int MW = 64;
  localparam int NP = NT / NL;
  localparam int PW = 1;
  localparam int TW = 2;
  localparam int LW = NL * XL;
  localparam int SNAPW = PW + 2 + NL + 3 * LW + TW + MW;

  typedef struct packed {
    logic [PW-1:0] pid;
    logic          sop;
    logic          eop;
    logic [NL-1:0] tmask;
    logic [LW-1:0] rs1;
    logic [LW-1:0] rs2;
    logic [LW-1:0] rs3;
    logic [TW-1:0] tid;
    logic [MW-1:0] meta;
  } pkt_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             in_valid, in_ready;
  logic [NT-1:0]    in_tmask;
  logic [NT*XL-1:0] in_rs1_data, in_rs2_data, in_rs3_data;
  logic [TW-1:0]    in_tid;
  logic [MW-1:0]    in_meta;
  logic             out_valid, out_ready;
  logic [NL-1:0]    out_tmask;
  logic [LW-1:0]    out_rs1_data, out_rs2_data, out_rs3_data;
  logic [TW-1:0]    out_tid;
  logic [MW-1:0]    out_meta;
  logic [PW-1:0]    out_pid;
  logic             out_sop, out_eop;

  pkt_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  bit   bp_en   = 1'b0;

  always #5 clk = ~clk;

  vx_alu_lane_splitter #(
    .NUM_THREADS (NT),
    .NUM_LANES   (NL),
    .XLEN        (XL),
    .META_WIDTH  (MW)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_tmask     (in_tmask),
    .in_rs1_data  (in_rs1_data),
    .in_rs2_data  (in_rs2_data),
    .in_rs3_data  (in_rs3_data),
    .in_tid       (in_tid),
    .in_meta      (in_meta),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_tmask    (out_tmask),
    .out_rs1_data (out_rs1_data),
    .out_rs2_data (out_rs2_data),
    .out_rs3_data (out_rs3_data),
    .out_tid      (out_tid),
    .out_meta     (out_meta),
    .out_pid      (out_pid),
    .out_sop      (out_sop),
    .out_eop      (out_eop)
  );

  task automatic chk(input string name, input logic [319:0] act, input logic [319:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: packet p holds threads p*NL..p*NL+NL-1; empty packets are dropped,
  // an entirely empty mask still yields packet 0; first gets sop, last gets eop.
  task automatic push_model(input logic [NT-1:0] m, input logic [NT*XL-1:0] r1,
                            input logic [NT*XL-1:0] r2, input logic [NT*XL-1:0] r3,
                            input logic [TW-1:0] tid, input logic [MW-1:0] meta);
    pkt_t lst[$];
    pkt_t k;
    for (int p = 0; p < NP; p++) begin
      if (m[p*NL +: NL] != 0 || (p == NP - 1 && lst.size() == 0 && m == 0)) begin
        int q;
        q = (m == 0) ? 0 : p;
        k.pid   = PW'(q);
        k.sop   = 1'b0;
        k.eop   = 1'b0;
        k.tmask = m[q*NL +: NL];
        k.rs1   = r1[q*LW +: LW];
        k.rs2   = r2[q*LW +: LW];
        k.rs3   = r3[q*LW +: LW];
        k.tid   = tid;
        k.meta  = meta;
        lst.push_back(k);
      end
    end
    lst[0].sop = 1'b1;
    lst[lst.size()-1].eop = 1'b1;
    foreach (lst[i]) exp_q.push_back(lst[i]);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (bp_en) out_ready = ($urandom_range(0, 3) != 0);
  endtask

  // Presents one instruction until accepted; returns at posedge+1 after the fire edge.
  task automatic issue(input logic [NT-1:0] m);
    bit fired = 1'b0;
    in_valid    = 1'b1;
    in_tmask    = m;
    in_rs1_data = {$urandom, $urandom, $urandom, $urandom};
    in_rs2_data = {$urandom, $urandom, $urandom, $urandom};
    in_rs3_data = {$urandom, $urandom, $urandom, $urandom};
    in_tid      = TW'($urandom_range(0, NT - 1));
    in_meta     = {$urandom, $urandom};
    for (int c = 0; c < 200 && !fired; c++) begin
      @(negedge clk);
      if (in_ready) begin
        push_model(in_tmask, in_rs1_data, in_rs2_data, in_rs3_data, in_tid, in_meta);
        fired = 1'b1;
      end
      step();
    end
    if (!fired) chk("issue_timeout", 1'b0, 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done = 1'b0;
    bp_en     = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 500 && !done; c++) begin
      @(negedge clk);
      done = (exp_q.size() == 0) && !out_valid;
    end
    if (!done) chk("drain_timeout", 1'b0, 1'b1);
    step();
  endtask

  task automatic monitor();
    bit   lat_pend  = 1'b0;
    bit   have_hold = 1'b0;
    logic [SNAPW-1:0] hold, snap;
    pkt_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        lat_pend  = 1'b0;
        have_hold = 1'b0;
      end else begin
        snap = {out_pid, out_sop, out_eop, out_tmask, out_rs1_data, out_rs2_data,
                out_rs3_data, out_tid, out_meta};
        if (lat_pend) chk("first_pkt_latency", out_valid, 1'b1);
        if (out_valid) begin
          if (exp_q.size() == 0) begin
            chk("spurious_packet", out_valid, 1'b0);
          end else begin
            e = exp_q[0];
            chk("pid",   out_pid,   e.pid);
            chk("sop",   out_sop,   e.sop);
            chk("eop",   out_eop,   e.eop);
            chk("tmask", out_tmask, e.tmask);
            chk("rs1",   out_rs1_data, e.rs1);
            chk("rs2",   out_rs2_data, e.rs2);
            chk("rs3",   out_rs3_data, e.rs3);
            chk("tid",   out_tid,   e.tid);
            chk("meta",  out_meta,  e.meta);
            chk("in_ready_busy", in_ready, out_ready && e.eop);
            if (have_hold) chk("stall_stable", snap, hold);
            if (out_ready) begin
              void'(exp_q.pop_front());
              have_hold = 1'b0;
            end else begin
              hold      = snap;
              have_hold = 1'b1;
            end
          end
        end else begin
          chk("in_ready_idle", in_ready, 1'b1);
          have_hold = 1'b0;
        end
        lat_pend = in_valid && in_ready;
      end
    end
  endtask

  initial begin
    reset       = 1'b1;
    in_valid    = 1'b0;
    in_tmask    = '0;
    in_rs1_data = '0;
    in_rs2_data = '0;
    in_rs3_data = '0;
    in_tid      = '0;
    in_meta     = '0;
    out_ready   = 1'b1;
    fork
      monitor();
    join_none
    repeat (3) step();
    reset = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready",  in_ready,  1'b1);
    step();

    // Full, upper-only and empty masks.
    issue(4'b1111);
    drain();
    issue(4'b1100);
    drain();
    issue(4'b0000);
    drain();
    issue(4'b0011);
    drain();

    // Hold pid0 for three cycles, then pid1 one cycle after release.
    issue(4'b1111);
    out_ready = 1'b0;
    repeat (3) step();
    out_ready = 1'b1;
    @(negedge clk);
    chk("stall_release_pid0", out_pid, 1'b0);
    step();
    @(negedge clk);
    chk("stall_then_pid1_valid", out_valid, 1'b1);
    chk("stall_then_pid1", out_pid, 1'b1);
    drain();

    // Back-to-back instructions: second accepted on the first one's eop.
    issue(4'b1111);
    issue(4'b1111);
    @(negedge clk);
    chk("b2b_second_pid0_valid", out_valid, 1'b1);
    chk("b2b_second_sop", out_sop, 1'b1);
    step();
    @(negedge clk);
    chk("b2b_second_pid1_valid", out_valid, 1'b1);
    chk("b2b_second_pid1", out_pid, 1'b1);
    drain();

    // Reset while pid1 is still pending.
    issue(4'b1111);
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("midreset_out_valid", out_valid, 1'b0);
    chk("midreset_in_ready",  in_ready,  1'b1);
    for (int i = 0; i < 3; i++) begin
      step();
      @(negedge clk);
      chk("midreset_no_residue", out_valid, 1'b0);
    end
    step();

    // Randomised traffic with output backpressure.
    bp_en = 1'b1;
    for (int n = 0; n < 150; n++) begin
      logic [NT-1:0] m;
      m = ($urandom_range(0, 5) == 0) ? 4'b0000 : NT'($urandom);
      issue(m);
      repeat ($urandom_range(0, 2)) step();
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vx_alu_lane_splitter.md
VX_ALU_LANE_SPLITTER -- requirements
Module: VX_alu_lane_splitter

Interface
REQ-001 Parameter NUM_THREADS, default 4: threads per warp instruction.
REQ-002 Parameter NUM_LANES, default 2: ALU datapath lanes; divides NUM_THREADS.
REQ-003 Parameter XLEN, default 32: operand width.
REQ-004 Parameter META_WIDTH, default 64: opaque per-instruction sideband (uuid, wid, op, PC, imm, rd, wb, ...), passed through unchanged.
REQ-005 Derived: NUM_PACKETS = NUM_THREADS/NUM_LANES; PID_WIDTH = UP(CLOG2(NUM_PACKETS)); TID_WIDTH = UP(CLOG2(NUM_THREADS)).
REQ-006 clk  in  1  single clock, rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 in_valid  in  1  warp instruction valid.
REQ-009 in_ready  out  1  instruction accepted when in_valid && in_ready.
REQ-010 in_tmask  in  NUM_THREADS  thread mask.
REQ-011 in_rs1_data / in_rs2_data / in_rs3_data  in  NUM_THREADS*XLEN each  per-thread operands.
REQ-012 in_tid  in  TID_WIDTH  leader thread index.
REQ-013 in_meta  in  META_WIDTH  sideband.
REQ-014 out_valid  out  1  packet valid.
REQ-015 out_ready  in  1  packet consumed when out_valid && out_ready.
REQ-016 out_tmask  out  NUM_LANES  packet slice of the thread mask.
REQ-017 out_rs1_data / out_rs2_data / out_rs3_data  out  NUM_LANES*XLEN each  packet operand slices.
REQ-018 out_tid, out_meta  out  TID_WIDTH, META_WIDTH  copies of the captured in_tid and in_meta.
REQ-019 out_pid  out  PID_WIDTH  packet index; out_sop / out_eop  out  1 each  first / last packet of the instruction.

Function
REQ-020 Packet p carries threads [p*NUM_LANES +: NUM_LANES]; lane i of packet p is thread p*NUM_LANES+i.
REQ-021 Emit only packets whose tmask slice is nonzero, in ascending pid order.
REQ-022 All-zero in_tmask: emit exactly one packet, pid 0, sop=eop=1, out_tmask 0.
REQ-023 sop=1 only on the first emitted packet; eop=1 only on the last; a single-packet instruction has sop=eop=1.
REQ-024 States IDLE and BUSY: IDLE->BUSY on input fire; BUSY->IDLE on output fire with eop and no same-cycle input fire; BUSY->BUSY with a new instruction on output fire with eop and same-cycle input fire.
REQ-025 in_ready = IDLE || (out_ready && out_eop); combinational, with no path from in_valid.
REQ-026 out_valid = BUSY; all out_* fields are driven from registered state plus the current pid only.
REQ-027 Latency: the first packet is valid in the cycle after input fire; throughput is one packet per cycle while out_ready=1.
REQ-028 With out_valid=1 and out_ready=0, every out_* signal holds stable.
REQ-029 On a non-eop output fire, pid advances to the next pid above the current one with a nonzero slice (skipping empty packets) in a single cycle.
REQ-030 NUM_LANES == NUM_THREADS: always one packet, pid 0, sop=eop=1.

Reset
REQ-031 Reset drives state to IDLE, pid to 0, out_valid to 0 and in_ready to 1 in the cycle after reset is sampled.
REQ-032 Reset mid-instruction discards remaining packets; no partial output follows.
REQ-033 Operand and meta registers need no reset.

Structure
REQ-034 NUM_PACKETS, PID_WIDTH and TID_WIDTH derivations belong in VX_gpu_pkg alongside the existing lane/pid constants.
REQ-035 Next-pid selection uses one VX_priority_encoder instance over (nonzero-slice mask & ~((1<<(pid+1))-1)).

Verification (NUM_THREADS=4, NUM_LANES=2)
REQ-036 tmask 4'b1111, out_ready=1 -> pid0 sop1 eop0 tmask 2'b11 lanes=threads0,1; next cycle pid1 sop0 eop1 lanes=threads2,3; in_ready=0 during pid0, 1 during pid1.
REQ-037 tmask 4'b1100 -> one packet pid1 sop1 eop1 tmask 2'b11, operands of threads 2,3.
REQ-038 tmask 4'b0000 -> one packet pid0 sop1 eop1 tmask 2'b00, meta intact.
REQ-039 out_ready=0 for 3 cycles during pid0 -> outputs unchanged for 3 cycles, then pid1 one cycle after out_ready rises.
REQ-040 Two back-to-back 4'b1111 instructions, out_ready=1 -> 4 packets in 4 consecutive cycles, second instruction accepted in the cycle of the first's eop.
REQ-041 Reset asserted while pid1 pending -> out_valid=0, in_ready=1 next cycle, no pid1 emitted.
